// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared decode constants and FSM state type for the EX-stage
// multiply/divide unit. The same opcode/function constants are used by the
// pipeline controller, so keep them in sync with the ISA decode tables.
package ex_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True for the four function codes that start a multi-cycle operation.
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) ||
           (f == FUNC_DIV)  || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: bundle between the ID/EX pipe register / controller (master)
// and the multiply/divide unit (slave).
//   master drives : flush, op_valid, opcode, func, rs_val, rt_val
//   slave drives  : stall_req, busy, hi, lo, mf_valid, mf_result
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            flush;
  logic            op_valid;
  logic [5:0]      opcode;
  logic [5:0]      func;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            stall_req;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            mf_valid;
  logic [XLEN-1:0] mf_result;

  modport master (
    output flush, op_valid, opcode, func, rs_val, rt_val,
    input  stall_req, busy, hi, lo, mf_valid, mf_result
  );

  modport slave (
    input  flush, op_valid, opcode, func, rs_val, rt_val,
    output stall_req, busy, hi, lo, mf_valid, mf_result
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit plus HI/LO register file in EX.
// MULT/MULTU/DIV/DIVU take 34 cycles in EX (33 of them stalling the front of
// the pipe); MTHI/MTLO write in one cycle; MFHI/MFLO read combinationally.
// Ports:
//   clk     clock
//   resetn  synchronous active-low reset (clears HI/LO, aborts any op)
//   bus     ex_muldiv_if.slave: instruction fields, forwarded operands,
//           flush in; stall_req, busy, hi, lo, mf_valid, mf_result out
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  ex_muldiv_if.slave  bus
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  // Shared accumulator: MUL {partial product, multiplier}; DIV {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       b_q, b_d;            // |multiplicand| or |divisor|
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;        // result / quotient sign
  logic                  neg_rem_q, neg_rem_d;// remainder takes dividend sign
  logic                  dz_q, dz_d;          // divide by zero
  logic                  stall_c;

  logic                  is_special, start, signed_op, s_a, s_b;
  logic [XLEN-1:0]       abs_a, abs_b;
  logic [XLEN:0]         mul_sum, div_pr, div_diff;
  logic [2*XLEN-1:0]     mul_next, div_next, prod;
  logic [XLEN-1:0]       res_hi, res_lo;

  assign is_special = bus.op_valid && (bus.opcode == OP_SPECIAL);
  assign start      = (state_q == S_IDLE) && is_special && is_muldiv(bus.func) && !bus.flush;
  assign signed_op  = (bus.func == FUNC_MULT) || (bus.func == FUNC_DIV);
  assign s_a        = signed_op && bus.rs_val[XLEN-1];
  assign s_b        = signed_op && bus.rt_val[XLEN-1];
  assign abs_a      = s_a ? -bus.rs_val : bus.rs_val;
  assign abs_b      = s_b ? -bus.rt_val : bus.rt_val;

  // Shift-add step: add multiplicand to upper half when LSB set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring step: shift in next dividend bit, subtract divisor, keep if non-negative.
  assign div_pr   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_pr - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_pr[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign fix. With rt=0 every quotient bit comes out 1 and the remainder is
  // |rs|, so re-signing the remainder restores rs; only LO needs forcing.
  assign prod   = neg_q ? -acc_q : acc_q;
  assign res_lo = !is_div_q ? prod[XLEN-1:0] :
                  dz_q      ? {XLEN{1'b1}} :
                  neg_q     ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign res_hi = !is_div_q ? prod[2*XLEN-1:XLEN] :
                  neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    stall_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_c   = 1'b1;
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = (bus.func == FUNC_DIV) || (bus.func == FUNC_DIVU);
          neg_d     = s_a ^ s_b;
          neg_rem_d = s_a;
          dz_d      = (bus.rt_val == '0);
          if ((bus.func == FUNC_DIV) || (bus.func == FUNC_DIVU)) begin
            acc_d = {{XLEN{1'b0}}, abs_a};
            b_d   = abs_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, abs_b};
            b_d   = abs_a;
          end
        end else if (is_special && (bus.func == FUNC_MTHI)) begin
          hi_d = bus.rs_val;
        end else if (is_special && (bus.func == FUNC_MTLO)) begin
          lo_d = bus.rs_val;
        end
      end
      S_CALC: begin
        stall_c = 1'b1;
        acc_d   = is_div_q ? div_next : mul_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush kills whatever is in EX: no HI/LO write, no stall.
    if (bus.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath registers are only meaningful inside an op; no reset needed.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    b_q       <= b_d;
    is_div_q  <= is_div_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

  assign bus.stall_req = resetn && stall_c;
  assign bus.busy      = resetn && (state_q != S_IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mf_valid  = resetn && (state_q == S_IDLE) && is_special &&
                         ((bus.func == FUNC_MFHI) || (bus.func == FUNC_MFLO));
  assign bus.mf_result = (is_special && (bus.func == FUNC_MFHI)) ? hi_q :
                         (is_special && (bus.func == FUNC_MFLO)) ? lo_q : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. Expected HI/LO pairs are
// queued when an op is issued and popped when the op retires.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference: 64-bit arithmetic, truncating division.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic   sgn;
    sgn = (f == FUNC_MULT) || (f == FUNC_DIV);
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if ((f == FUNC_MULT) || (f == FUNC_MULTU)) begin
      p = sa * sb;
      return p[63:0];
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    bus.opcode   = OP_SPECIAL;
    bus.func     = 6'h00;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle MTHI/MTLO issue.
  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    bus.op_valid = 1'b1; bus.opcode = OP_SPECIAL; bus.func = f; bus.rs_val = v;
    step();
    bus.op_valid = 1'b0;
  endtask

  // Issue a mul/div op, count stall cycles, retire it and score HI/LO.
  task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int stalls;
    logic [63:0] exp;
    exp_q.push_back({eh, el});
    bus.op_valid = 1'b1; bus.opcode = OP_SPECIAL; bus.func = f;
    bus.rs_val = a; bus.rt_val = b;
    #1;
    stalls = 0;
    while (bus.stall_req && stalls < 100) begin
      stalls++;
      step();
    end
    checks++;
    if (stalls !== 33) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected 33", name, stalls);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b expected 1", name, bus.busy);
    end
    step();
    bus.op_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL %s hi_lo: got %h_%h expected %h_%h", name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    $display("op %s rs=%h rt=%h -> hi=%h lo=%h stalls=%0d", name, a, b, bus.hi, bus.lo, stalls);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.op_valid = 1'b1; bus.func = FUNC_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req); end
    step(); step();
    bus.func = FUNC_MFHI;
    #1;
    checks++;
    if (bus.mf_valid !== 1'b0) begin errors++; $display("FAIL reset_mf_valid: got %b expected 0", bus.mf_valid); end
    checks++;
    if ({bus.hi, bus.lo, bus.busy} !== 65'h0) begin
      errors++; $display("FAIL reset_state: got hi=%h lo=%h busy=%b expected zeros", bus.hi, bus.lo, bus.busy);
    end
    idle_inputs();
    resetn = 1'b1;
    step();
    $display("reset: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
  endtask

  task automatic test_mult();
    do_op("MULT_7x6", FUNC_MULT, 32'd7, 32'd6, 32'h0, 32'd42);
    bus.op_valid = 1'b1; bus.func = FUNC_MFLO;
    #1;
    checks++;
    if (bus.mf_valid !== 1'b1 || bus.mf_result !== 32'd42 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL mflo_after_mult: got valid=%b result=%h stall=%b expected 1/0000002a/0",
               bus.mf_valid, bus.mf_result, bus.stall_req);
    end
    $display("MFLO -> %h", bus.mf_result);
    step();
    bus.op_valid = 1'b0;
    do_op("MULT_m1x2", FUNC_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("MULTU_m1x2", FUNC_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    do_op("DIV_m7d2", FUNC_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("DIVU_7d0", FUNC_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    do_op("DIV_m5d0", FUNC_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    do_op("DIV_min_dm1", FUNC_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    do_op("DIV_7dm2", FUNC_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
  endtask

  task automatic test_mt_mf();
    bus.op_valid = 1'b1; bus.func = FUNC_MTHI; bus.rs_val = 32'hA5A5A5A5;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus.stall_req); end
    step();
    bus.func = FUNC_MFHI;
    #1;
    checks++;
    if (bus.mf_valid !== 1'b1 || bus.mf_result !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL mfhi_b2b: got valid=%b result=%h expected 1/a5a5a5a5", bus.mf_valid, bus.mf_result);
    end
    $display("MTHI a5a5a5a5 then MFHI -> %h", bus.mf_result);
    bus.func = FUNC_MTLO; bus.rs_val = 32'h0F0F0F0F;
    step();
    bus.func = FUNC_MFLO;
    #1;
    checks++;
    if (bus.mf_result !== 32'h0F0F0F0F) begin
      errors++; $display("FAIL mflo_b2b: got %h expected 0f0f0f0f", bus.mf_result);
    end
    bus.opcode = 6'h08; bus.func = FUNC_MFHI;
    #1;
    checks++;
    if (bus.mf_valid !== 1'b0 || bus.mf_result !== 32'h0) begin
      errors++; $display("FAIL mf_non_special: got valid=%b result=%h expected 0/0", bus.mf_valid, bus.mf_result);
    end
    $display("non-special MFHI -> valid=%b result=%h", bus.mf_valid, bus.mf_result);
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    mt(FUNC_MTHI, 32'h11112222);
    mt(FUNC_MTLO, 32'h33334444);
    bus.op_valid = 1'b1; bus.func = FUNC_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    step();
    repeat (10) step();
    bus.flush = 1'b1; bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL flush_cycle: got stall=%b busy=%b expected 0/1", bus.stall_req, bus.busy);
    end
    step();
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got busy=%b stall=%b expected 0/0", bus.busy, bus.stall_req);
    end
    checks++;
    if (bus.hi !== 32'h11112222 || bus.lo !== 32'h33334444) begin
      errors++; $display("FAIL flush_hilo: got %h_%h expected 11112222_33334444", bus.hi, bus.lo);
    end
    $display("flush at cnt=10: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    do_op("MULT_after_flush", FUNC_MULT, 32'd3, 32'd5, 32'h0, 32'd15);
  endtask

  task automatic test_reset_midop();
    mt(FUNC_MTHI, 32'h1234);
    mt(FUNC_MTLO, 32'h1234);
    bus.op_valid = 1'b1; bus.func = FUNC_MULT; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    step();
    repeat (5) step();
    resetn = 1'b0; bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_midop_comb: got busy=%b stall=%b expected 0/0", bus.busy, bus.stall_req);
    end
    step();
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_midop_state: got hi=%h lo=%h busy=%b expected 0/0/0", bus.hi, bus.lo, bus.busy);
    end
    bus.op_valid = 1'b0; bus.func = FUNC_MULT;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL bubble_mult_stall: got %b expected 0", bus.stall_req); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bubble_mult_busy: got %b expected 0", bus.busy); end
    $display("reset mid-op: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  funcs [4];
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [63:0] e;
    funcs[0] = FUNC_MULT; funcs[1] = FUNC_MULTU; funcs[2] = FUNC_DIV; funcs[3] = FUNC_DIVU;
    for (int i = 0; i < 8; i++) begin
      f = funcs[i % 4];
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i[0] && (f == FUNC_DIV || f == FUNC_MULT)) b = -b;
      e = model(f, a, b);
      do_op($sformatf("rand%0d_f%h", i, f), f, a, b, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
